// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port DataMemory between the CPU MEM stage and a DMA
// requester (e.g. a UART receive engine). The CPU wins by default. A 4-bit
// starvation counter forces one DMA slot after STARVE_LIMIT denied cycles and
// raises o_cpu_stall for exactly that cycle so the hazard unit freezes the
// pipeline. Every DMA grant is followed by an ARB_ACK cycle that belongs to
// the CPU, so a stall can never last two consecutive cycles.
//
// Parameters
//   ADDR_W        word address width (DataMemory index width)
//   DATA_W        data width
//   STARVE_LIMIT  denied DMA cycles before a forced grant, 1..15
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   i_cpu_read/i_cpu_write     MEM-stage load/store strobes
//   i_cpu_address/_write_data  CPU word address and store data
//   o_cpu_read_data            CPU load data (combinational pass-through)
//   o_cpu_stall                CPU access blocked this cycle
//   i_dma_req/_we/_address/_write_data   DMA request (level, held to ack)
//   o_dma_ack                  registered one-cycle completion pulse
//   o_dma_read_data            registered DMA read data, held to next read
//   o_mem_*                    DataMemory port (address, data, write, read)
//   i_mem_read_data            DataMemory combinational read data
//
// Build option
//   DMEM_ARB_STATS_EN  adds o_stall_count[15:0], a saturating count of
//                      cycles with o_cpu_stall=1.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              i_cpu_read,
  input  logic              i_cpu_write,
  input  logic [ADDR_W-1:0] i_cpu_address,
  input  logic [DATA_W-1:0] i_cpu_write_data,
  output logic [DATA_W-1:0] o_cpu_read_data,
  output logic              o_cpu_stall,

  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [ADDR_W-1:0] i_dma_address,
  input  logic [DATA_W-1:0] i_dma_write_data,
  output logic              o_dma_ack,
  output logic [DATA_W-1:0] o_dma_read_data,

  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_write,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_read_data
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       o_stall_count
`endif
);

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ACK  = 1'b1
  } arb_state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  logic [3:0]  starve_cnt;
  logic        cpu_acc;
  logic        dma_pend;
  logic        force_grant;
  logic        dma_grant;

  assign cpu_acc     = i_cpu_read | i_cpu_write;
  assign dma_pend    = i_dma_req & (state_q == ARB_IDLE);
  assign force_grant = dma_pend & cpu_acc & (starve_cnt >= LIMIT);
  assign dma_grant   = dma_pend & (~cpu_acc | force_grant);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each always_comb guarantees
  // every path drives the signal, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (dma_grant) state_d = ARB_ACK;
      ARB_ACK:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (memory port mux and CPU stall)
  // ---------------------------------------------------------------------------
  // On a forced grant the CPU sees DMA read data on o_cpu_read_data, but the
  // stall bubbles MEM/WB so that value is never written back.
  always_comb begin
    o_mem_address    = i_cpu_address;
    o_mem_write_data = i_cpu_write_data;
    o_mem_write      = i_cpu_write;
    o_mem_read       = i_cpu_read & ~i_cpu_write;  // a store wins over a load
    if (dma_grant) begin
      o_mem_address    = i_dma_address;
      o_mem_write_data = i_dma_write_data;
      o_mem_write      = i_dma_we;
      o_mem_read       = ~i_dma_we;
    end
    o_cpu_stall = force_grant;
  end

  assign o_cpu_read_data = i_mem_read_data;

  // ---------------------------------------------------------------------------
  // DMA completion: ack is high only in the cycle after a grant, which is the
  // ARB_ACK cycle; read data is captured only on DMA reads and otherwise held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_dma_ack       <= 1'b0;
      o_dma_read_data <= '0;
    end else begin
      o_dma_ack <= dma_grant;
      if (dma_grant && !i_dma_we) o_dma_read_data <= i_mem_read_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: counts contended cycles of a pending request, clears on
  // grant or when the requester withdraws. Saturates so a long stall of the
  // CPU path cannot wrap it back below the limit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (dma_grant)                  starve_cnt <= '0;
      else if (dma_pend && cpu_acc) begin
        if (starve_cnt != 4'hF)       starve_cnt <= starve_cnt + 4'd1;
      end
      else if (!i_dma_req)            starve_cnt <= '0;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Saturating count of stalled CPU cycles, read back by PeripheralControl.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    o_stall_count <= '0;
    else if (force_grant && o_stall_count != 16'hFFFF) o_stall_count <= o_stall_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. A behavioural DataMemory (combinational
// read, clocked write) sits on the arbiter's memory port. Expected DMA results
// are pushed to a scoreboard queue when a request is driven and popped when
// o_dma_ack is observed: reads compare o_dma_read_data, writes compare the
// memory contents. Inputs change 1 ns after the rising edge; outputs are
// sampled between edges.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } dma_exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_read, cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              dma_req, dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write, mem_read;
  logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]       stall_count;
`endif

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  dma_exp_t          sb_q[$];
  dma_exp_t          exp_e;
  logic [DATA_W-1:0] act;
  int                n_cmp = 0;
  int                n_bad = 0;
  int                exp_stalls = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)) dut (
`ifdef DMEM_ARB_STATS_EN
    .o_stall_count   (stall_count),
`endif
    .clk             (clk),
    .reset           (reset),
    .i_cpu_read      (cpu_read),
    .i_cpu_write     (cpu_write),
    .i_cpu_address   (cpu_addr),
    .i_cpu_write_data(cpu_wdata),
    .o_cpu_read_data (cpu_rdata),
    .o_cpu_stall     (cpu_stall),
    .i_dma_req       (dma_req),
    .i_dma_we        (dma_we),
    .i_dma_address   (dma_addr),
    .i_dma_write_data(dma_wdata),
    .o_dma_ack       (dma_ack),
    .o_dma_read_data (dma_rdata),
    .o_mem_address   (mem_addr),
    .o_mem_write_data(mem_wdata),
    .o_mem_write     (mem_write),
    .o_mem_read      (mem_read),
    .i_mem_read_data (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural DataMemory
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  // Bound on total run time
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic dma_drive(input logic req, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    dma_req = req; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  task automatic cpu_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick();
    cpu_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    reset = 1'b0;
    dma_drive(1'b0, 1'b0, '0, '0);
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 9'h007; cpu_wdata = 32'h1111_2222;
    #2;
    n_cmp++;
    if ({dma_ack, dma_rdata, cpu_stall} !== {1'b0, 32'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_regs: ack=%b rdata=%h stall=%b want 0/0/0", dma_ack, dma_rdata, cpu_stall);
    end
    n_cmp++;
    if ({mem_addr, mem_read, mem_write, mem_wdata} !== {9'h007, 1'b1, 1'b0, 32'h1111_2222}) begin
      n_bad++;
      $display("FAIL reset_cpu_mux: addr=%h rd=%b wr=%b wd=%h want 007/1/0/11112222",
               mem_addr, mem_read, mem_write, mem_wdata);
    end
    // During reset the FSM is in ARB_IDLE, so an uncontended DMA request is on the port.
    cpu_idle();
    dma_drive(1'b1, 1'b1, 9'h055, 32'h5555_0000);
    #1;
    n_cmp++;
    if ({mem_addr, mem_write, mem_read, mem_wdata} !== {9'h055, 1'b1, 1'b0, 32'h5555_0000}) begin
      n_bad++;
      $display("FAIL reset_dma_mux: addr=%h wr=%b rd=%b wd=%h want 055/1/0/55550000",
               mem_addr, mem_write, mem_read, mem_wdata);
    end
    dma_drive(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_cpu_path;
    cpu_store(9'h010, 32'hDEAD_BEEF);
    cpu_store(9'h011, 32'hA5A5_0011);
    cpu_store(9'h005, 32'h0000_0555);
    cpu_store(9'h040, 32'h0000_0000);
    // Plain load: zero-latency pass-through of memory data.
    cpu_read = 1'b1; cpu_addr = 9'h011;
    #1;
    n_cmp++;
    if ({cpu_rdata, mem_read, mem_write, cpu_stall} !== {32'hA5A5_0011, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL cpu_load: rdata=%h rd=%b wr=%b stall=%b want a5a50011/1/0/0",
               cpu_rdata, mem_read, mem_write, cpu_stall);
    end
    // Simultaneous read and write: the write wins.
    cpu_write = 1'b1; cpu_addr = 9'h022; cpu_wdata = 32'h0BEE_F022;
    #1;
    n_cmp++;
    if ({mem_write, mem_read} !== 2'b10) begin
      n_bad++;
      $display("FAIL cpu_rd_wr: wr=%b rd=%b want 1/0", mem_write, mem_read);
    end
    tick();
    cpu_idle();
    n_cmp++;
    if (mem[9'h022] !== 32'h0BEE_F022) begin
      n_bad++;
      $display("FAIL cpu_store_commit: mem=%h want 0beef022", mem[9'h022]);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_idle_dma_read;
    cpu_idle();
    dma_drive(1'b1, 1'b0, 9'h010, '0);
    sb_q.push_back('{we: 1'b0, addr: 9'h010, data: 32'hDEAD_BEEF});
    #1;
    n_cmp++;
    if ({mem_addr, mem_read, mem_write, cpu_stall, dma_ack} !== {9'h010, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL idle_rd_grant: addr=%h rd=%b wr=%b stall=%b ack=%b want 010/1/0/0/0",
               mem_addr, mem_read, mem_write, cpu_stall, dma_ack);
    end
    tick();
    dma_drive(1'b0, 1'b0, '0, '0);
    n_cmp++;
    if ({dma_ack, cpu_stall} !== 2'b10) begin
      n_bad++;
      $display("FAIL idle_rd_ack: ack=%b stall=%b want 1/0", dma_ack, cpu_stall);
    end
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL idle_rd_data: scoreboard empty at ack");
    end else begin
      exp_e = sb_q.pop_front();
      act = exp_e.we ? mem[exp_e.addr] : dma_rdata;
      if (act !== exp_e.data) begin
        n_bad++;
        $display("FAIL idle_rd_data: got %h want %h", act, exp_e.data);
      end
    end
    tick();
    n_cmp++;
    if ({dma_ack, dma_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL idle_rd_hold: ack=%b rdata=%h want 0/deadbeef", dma_ack, dma_rdata);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_starvation;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 9'h005;
    dma_drive(1'b1, 1'b1, 9'h020, 32'h1234_5678);
    sb_q.push_back('{we: 1'b1, addr: 9'h020, data: 32'h1234_5678});
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      n_cmp++;
      if ({cpu_stall, mem_addr, mem_write, dma_ack, cpu_rdata} !== {1'b0, 9'h005, 1'b0, 1'b0, 32'h0000_0555}) begin
        n_bad++;
        $display("FAIL starve_deny[%0d]: stall=%b addr=%h wr=%b ack=%b rdata=%h want 0/005/0/0/00000555",
                 i, cpu_stall, mem_addr, mem_write, dma_ack, cpu_rdata);
      end
      tick();
    end
    #1;
    n_cmp++;
    if ({cpu_stall, mem_addr, mem_write, mem_read} !== {1'b1, 9'h020, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL starve_force: stall=%b addr=%h wr=%b rd=%b want 1/020/1/0",
               cpu_stall, mem_addr, mem_write, mem_read);
    end
    exp_stalls++;
    tick();
    dma_drive(1'b0, 1'b0, '0, '0);
    n_cmp++;
    if ({dma_ack, cpu_stall, mem_addr} !== {1'b1, 1'b0, 9'h005}) begin
      n_bad++;
      $display("FAIL starve_ack: ack=%b stall=%b addr=%h want 1/0/005", dma_ack, cpu_stall, mem_addr);
    end
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL starve_data: scoreboard empty at ack");
    end else begin
      exp_e = sb_q.pop_front();
      act = exp_e.we ? mem[exp_e.addr] : dma_rdata;
      if (act !== exp_e.data) begin
        n_bad++;
        $display("FAIL starve_data: got %h want %h", act, exp_e.data);
      end
    end
`ifdef DMEM_ARB_STATS_EN
    n_cmp++;
    if (stall_count !== 16'(exp_stalls)) begin
      n_bad++;
      $display("FAIL starve_stat: stall_count=%0d want %0d", stall_count, exp_stalls);
    end
`endif
    tick();
    cpu_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back;
    cpu_idle();
    dma_drive(1'b1, 1'b0, 9'h011, '0);
    sb_q.push_back('{we: 1'b0, addr: 9'h011, data: 32'hA5A5_0011});
    #1;
    n_cmp++;
    if ({mem_addr, mem_read} !== {9'h011, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_grant1: addr=%h rd=%b want 011/1", mem_addr, mem_read);
    end
    tick();
    // Ack cycle: request still held, CPU stores; CPU must own the port.
    cpu_write = 1'b1; cpu_addr = 9'h030; cpu_wdata = 32'hCAFE_0001;
    #1;
    n_cmp++;
    if ({dma_ack, mem_addr, mem_write, mem_read, cpu_stall} !== {1'b1, 9'h030, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_ack_cycle: ack=%b addr=%h wr=%b rd=%b stall=%b want 1/030/1/0/0",
               dma_ack, mem_addr, mem_write, mem_read, cpu_stall);
    end
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL b2b_data1: scoreboard empty at ack");
    end else begin
      exp_e = sb_q.pop_front();
      act = exp_e.we ? mem[exp_e.addr] : dma_rdata;
      if (act !== exp_e.data) begin
        n_bad++;
        $display("FAIL b2b_data1: got %h want %h", act, exp_e.data);
      end
    end
    tick();
    cpu_idle();
    sb_q.push_back('{we: 1'b0, addr: 9'h011, data: 32'hA5A5_0011});
    #1;
    n_cmp++;
    if ({mem[9'h030], dma_ack, mem_addr, mem_read} !== {32'hCAFE_0001, 1'b0, 9'h011, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_regrant: mem30=%h ack=%b addr=%h rd=%b want cafe0001/0/011/1",
               mem[9'h030], dma_ack, mem_addr, mem_read);
    end
    tick();
    dma_drive(1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (dma_ack !== 1'b1 || sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL b2b_ack2: ack=%b queued=%0d want 1/1", dma_ack, sb_q.size());
    end else begin
      exp_e = sb_q.pop_front();
      act = exp_e.we ? mem[exp_e.addr] : dma_rdata;
      if (act !== exp_e.data) begin
        n_bad++;
        $display("FAIL b2b_data2: got %h want %h", act, exp_e.data);
      end
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_withdraw;
    cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 9'h005;
    dma_drive(1'b1, 1'b1, 9'h040, 32'h0BAD_F00D);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({cpu_stall, mem_addr, mem_write} !== {1'b0, 9'h005, 1'b0}) begin
        n_bad++;
        $display("FAIL wd_deny[%0d]: stall=%b addr=%h wr=%b want 0/005/0", i, cpu_stall, mem_addr, mem_write);
      end
      tick();
    end
    dma_drive(1'b0, 1'b0, '0, '0);
    tick();
    n_cmp++;
    if ({dma_ack, mem[9'h040]} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL wd_no_access: ack=%b mem40=%h want 0/00000000", dma_ack, mem[9'h040]);
    end
    dma_drive(1'b1, 1'b1, 9'h040, 32'h5A5A_5A5A);
    sb_q.push_back('{we: 1'b1, addr: 9'h040, data: 32'h5A5A_5A5A});
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      n_cmp++;
      if ({cpu_stall, mem_addr, dma_ack} !== {1'b0, 9'h005, 1'b0}) begin
        n_bad++;
        $display("FAIL wd_fresh_deny[%0d]: stall=%b addr=%h ack=%b want 0/005/0", i, cpu_stall, mem_addr, dma_ack);
      end
      tick();
    end
    #1;
    n_cmp++;
    if ({cpu_stall, mem_addr, mem_write} !== {1'b1, 9'h040, 1'b1}) begin
      n_bad++;
      $display("FAIL wd_force: stall=%b addr=%h wr=%b want 1/040/1", cpu_stall, mem_addr, mem_write);
    end
    exp_stalls++;
    tick();
    dma_drive(1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (dma_ack !== 1'b1 || sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL wd_ack: ack=%b queued=%0d want 1/1", dma_ack, sb_q.size());
    end else begin
      exp_e = sb_q.pop_front();
      act = exp_e.we ? mem[exp_e.addr] : dma_rdata;
      if (act !== exp_e.data) begin
        n_bad++;
        $display("FAIL wd_data: got %h want %h", act, exp_e.data);
      end
    end
`ifdef DMEM_ARB_STATS_EN
    n_cmp++;
    if (stall_count !== 16'(exp_stalls)) begin
      n_bad++;
      $display("FAIL wd_stat: stall_count=%0d want %0d", stall_count, exp_stalls);
    end
`endif
    tick();
    cpu_idle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset;
    cpu_idle();
    dma_drive(1'b1, 1'b1, 9'h060, 32'h6060_6060);
    tick();
    dma_drive(1'b0, 1'b0, '0, '0);
    n_cmp++;
    if ({dma_ack, mem[9'h060]} !== {1'b1, 32'h6060_6060}) begin
      n_bad++;
      $display("FAIL arst_pre_ack: ack=%b mem60=%h want 1/60606060", dma_ack, mem[9'h060]);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({dma_ack, dma_rdata, mem[9'h060]} !== {1'b0, 32'h0, 32'h6060_6060}) begin
      n_bad++;
      $display("FAIL arst_clear: ack=%b rdata=%h mem60=%h want 0/00000000/60606060",
               dma_ack, dma_rdata, mem[9'h060]);
    end
`ifdef DMEM_ARB_STATS_EN
    n_cmp++;
    if (stall_count !== 16'h0) begin
      n_bad++;
      $display("FAIL arst_stat: stall_count=%0d want 0", stall_count);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    tick();
    // Back in ARB_IDLE: a new uncontended request is granted immediately.
    dma_drive(1'b1, 1'b0, 9'h010, '0);
    sb_q.push_back('{we: 1'b0, addr: 9'h010, data: 32'hDEAD_BEEF});
    #1;
    n_cmp++;
    if ({mem_addr, mem_read, cpu_stall} !== {9'h010, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL arst_idle_grant: addr=%h rd=%b stall=%b want 010/1/0", mem_addr, mem_read, cpu_stall);
    end
    tick();
    dma_drive(1'b0, 1'b0, '0, '0);
    n_cmp++;
    if (dma_ack !== 1'b1 || sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL arst_ack: ack=%b queued=%0d want 1/1", dma_ack, sb_q.size());
    end else begin
      exp_e = sb_q.pop_front();
      act = exp_e.we ? mem[exp_e.addr] : dma_rdata;
      if (act !== exp_e.data) begin
        n_bad++;
        $display("FAIL arst_data: got %h want %h", act, exp_e.data);
      end
    end
    tick();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    cpu_idle();
    dma_drive(1'b0, 1'b0, '0, '0);
    test_reset();
    test_cpu_path();
    test_idle_dma_read();
    test_starvation();
    test_back_to_back();
    test_withdraw();
    test_async_reset();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d expected DMA results never acknowledged", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the CPU MEM stage and a DMA requester, such as a UART receive engine. The CPU has priority by default. A starvation counter forces a DMA slot after a bounded number of denied cycles, and it stalls the CPU for that one cycle via `o_cpu_stall`, which feeds the hazard unit. The arbiter sits between the EX/MEM register outputs and the DataMemory instance; the memory's combinational read and clocked write are unchanged.

## Interface
- `ADDR_W`, default 9: word address width, equal to the DataMemory index width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 4: denied DMA cycles before a forced grant. Legal range is 1..15.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `i_cpu_read`  in  1  MEM-stage load.
- `i_cpu_write`  in  1  MEM-stage store.
- `i_cpu_address`  in  ADDR_W  CPU word address.
- `i_cpu_write_data`  in  DATA_W  CPU store data.
- `o_cpu_read_data`  out  DATA_W  CPU load data, combinational pass-through.
- `o_cpu_stall`  out  1  CPU access blocked this cycle; freeze PC, IF/ID, ID/EX and EX/MEM; bubble MEM/WB.
- `i_dma_req`  in  1  DMA request, level; held until ack.
- `i_dma_we`  in  1  DMA write (1) or read (0).
- `i_dma_address`  in  ADDR_W  DMA word address.
- `i_dma_write_data`  in  DATA_W  DMA write data.
- `o_dma_ack`  out  1  one-cycle completion pulse, registered.
- `o_dma_read_data`  out  DATA_W  registered DMA read data, valid while `o_dma_ack`=1 and held until the next DMA read.
- `o_mem_address`  out  ADDR_W  to DataMemory.
- `o_mem_write_data`  out  DATA_W  to DataMemory.
- `o_mem_write`  out  1  to DataMemory.
- `o_mem_read`  out  1  to DataMemory.
- `i_mem_read_data`  in  DATA_W  from DataMemory.

## Operation
- **FSM states:** ARB_IDLE and ARB_ACK. The state register, the starvation counter `starve_cnt` (4 bits), `o_dma_ack` and `o_dma_read_data` are all registered.
- **Definitions:**
  - `cpu_acc` = `i_cpu_read` | `i_cpu_write`.
  - `dma_pend` = `i_dma_req` & (state==ARB_IDLE).
  - `force` = `dma_pend` & `cpu_acc` & (`starve_cnt` >= STARVE_LIMIT).
  - `dma_grant` = `dma_pend` & (!`cpu_acc` | `force`).
- **Port mux (combinational):**
  - When `dma_grant`=1, the memory port carries the DMA address and data; `o_mem_write` = `i_dma_we`; `o_mem_read` = !`i_dma_we`.
  - Otherwise the memory port carries the CPU signals.
  - `o_cpu_stall` = `force`.
- **ARB_IDLE:**
  - If `dma_grant`: at the clock edge, the write commits (if any); `o_dma_read_data` <= `i_mem_read_data` on a read; `o_dma_ack` <= 1; `starve_cnt` <= 0; go to ARB_ACK.
  - Else if `dma_pend` & `cpu_acc`: `starve_cnt` <= `starve_cnt`+1, saturating at 15.
  - Else if !`i_dma_req`: `starve_cnt` <= 0.
- **ARB_ACK:**
  - `o_dma_ack` <= 0 and the FSM returns to ARB_IDLE.
  - `i_dma_req` is ignored in this cycle; the requester drops or re-presents it.
  - The CPU owns the port unconditionally; no stall.
- **Simultaneous CPU read and write:** write wins; `o_mem_read`=0.

## Timing
- **Reset values:** state=ARB_IDLE, `starve_cnt`=0, `o_dma_ack`=0, `o_dma_read_data`=0. All combinational outputs follow their inputs with state=ARB_IDLE.
- **CPU latency:** 0 cycles; this is a pure mux in the non-grant case.
- **DMA latency:**
  - Uncontended: ack in the cycle after the request is first seen.
  - Contended: ack at most STARVE_LIMIT+1 cycles after the request is first seen.
  - Maximum DMA throughput is 1 access per 2 cycles.
- **Stall width:** `o_cpu_stall` is never high for 2 consecutive cycles, because ARB_ACK follows every grant.
- **Reset mid-operation:** an asynchronous assert during ARB_ACK clears the ack immediately. A DMA write already clocked into memory is not undone.
- **DMA request dropped before ack:** the counter clears and no access occurs.

## Configuration
- **`DMEM_ARB_STATS_EN` defined:** adds output `o_stall_count`, 16 bits.
  - Increments on each cycle with `o_cpu_stall`=1 and saturates at 16'hFFFF.
  - Reset value 0.
  - Intended for mapping to a peripheral read address by PeripheralControl.
- **`DMEM_ARB_STATS_EN` undefined:** the port and the counter are absent; behaviour is otherwise identical.

## Test plan
- **Idle DMA read:** CPU idle, DMA read of addr 9'h010 holding 32'hDEADBEEF → `o_mem_read`=1 from DMA in cycle 0; `o_dma_ack`=1 in cycle 1 with `o_dma_read_data`=32'hDEADBEEF; `o_cpu_stall` stays 0.
- **Starvation force:** CPU loads every cycle; DMA write 32'h12345678 to addr 9'h020; STARVE_LIMIT=4 → 4 denied cycles, then `o_cpu_stall`=1 for exactly 1 cycle with DMA on the port; ack next cycle; memory[0x20]=32'h12345678.
- **Ack-cycle request ignored:** DMA holds `i_dma_req` through the ack cycle with a CPU store to 9'h030 in that cycle → store commits; no second DMA grant in the ack cycle; new grant the following cycle if the CPU is idle.
- **Request withdrawn:** `i_dma_req` dropped after 2 contended cycles → `starve_cnt` returns to 0; a later request needs a fresh 4 denials before force.
- **Asynchronous reset in ARB_ACK:** `reset`=0 mid-cycle → `o_dma_ack` drops immediately; state=ARB_IDLE; with `DMEM_ARB_STATS_EN`, `o_stall_count`=0.
